pipemem_stage: RTL and testbench
================================

# pipemem_stage

Memory-access (MEM) stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register, owns the word-addressed data memory, and produces the load result `mmo` consumed by MEM/WB. It models a data memory with a configurable number of wait states. While an access is in progress it asserts `mstall` to freeze the upstream stages, and it gates the register-write enable so MEM/WB never captures a duplicate write.

## Interface
- `AW`, default 5: word-address width; the memory holds 2^AW 32-bit words.
- `WAIT_CYCLES`, default 2: wait states per memory access; legal range 0–15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `clrn`  in  1  reset, synchronous, active-low.
- `mwreg`  in  1  register-write enable from EX/MEM.
- `mm2reg`  in  1  load indicator from EX/MEM.
- `mwmem`  in  1  store enable from EX/MEM.
- `malu`  in  32  byte address from EX/MEM.
- `mb`  in  32  store data from EX/MEM.
- `mmo`  out  32  load data, to MEM/WB.
- `mwreg_o`  out  1  gated write enable, to MEM/WB (`mwreg & ~mstall`).
- `mstall`  out  1  freeze request to PC, IF/ID, ID/EX and EX/MEM.
- `merr`  out  1  sticky misalignment flag; exists only with the configuration macro.

## Operation
- `memop = mm2reg | mwmem`. If both bits are set, the access is treated as a store. `mmo` still shows the word before the write.
- Word index is `malu[AW+1:2]`. Upper address bits are ignored, so addresses wrap modulo 2^(AW+2).
- FSM states:
  - IDLE (cnt=0).
  - WAIT, with a 4-bit counter `cnt`.
- Transitions:
  - IDLE → WAIT when `memop` and `WAIT_CYCLES>0`; the next value of `cnt` is 1.
  - WAIT: `cnt` increments each cycle. When `cnt==WAIT_CYCLES`, the access completes and the next state is IDLE with cnt=0.
  - `memop` dropping while in WAIT does not happen, because upstream is frozen. If it does happen anyway, go to IDLE, cnt=0, and commit no store.
- Stall: `mstall = memop & (cnt != WAIT_CYCLES)`. When `WAIT_CYCLES=0`, `mstall` is always 0.
- Completion cycle is the cycle where `memop` is high and `mstall` is low.
  - A store writes `mb` to `mem[index]` on the rising edge that ends this cycle.
  - No write happens on any stalled cycle.
- Load data: `mmo = mem[index]`, an asynchronous read, driven whenever `clrn` is high. It is valid in the completion cycle. For non-memory instructions it is don't-care but deterministic (still the array read).
- Memory array contents are not reset.

## Timing
- Each access occupies `WAIT_CYCLES+1` cycles; `mstall` is high for the first `WAIT_CYCLES` of them.
- Back-to-back accesses:
  - The cycle after a completion starts a fresh access at cnt=0. The stall re-asserts immediately, with no idle bubble.
  - A load that follows a store to the same word returns the new data.
- A non-memory instruction never stalls; `mwreg_o = mwreg`.
- Reset (`clrn=0` sampled at an edge):
  - Next state IDLE, cnt=0, `merr`=0.
  - While `clrn` is low, `mstall`=0, `mwreg_o`=0 and `mmo`=0, and no store is committed, even if reset arrives in the completion cycle.
  - Reset mid-access abandons the access.
- The reset value of every output is 0.

## Configuration
- Macro: `PIPEMEM_ALIGN_CHECK_EN`.
- Defined:
  - An access with `malu[1:0]!=0` sets `merr` on its completion edge. `merr` stays high until reset.
  - The store is suppressed on that access.
  - The load still returns `mem[index]`.
  - Stall timing is unchanged.
- Undefined:
  - There is no `merr` port.
  - `malu[1:0]` is ignored entirely, and misaligned stores write normally.

## Test plan
1. Reset, then store `mb=32'hDEADBEEF` at `malu=32'h10` with WAIT_CYCLES=2 → `mstall`=1,1,0 over three cycles; a later load from `32'h10` returns `32'hDEADBEEF` in its third cycle, and `mwreg_o` is high only in that cycle.
2. WAIT_CYCLES=0: store `32'h1` at `0x4`, then immediately load from `0x4` → `mstall` is never high; load `mmo=32'h1`.
3. Assert `clrn=0` during cycle 2 of a 3-cycle store of `32'hAAAA5555` to `0x8` → after reset, a load from `0x8` returns the old value; outputs are 0 during reset; cnt restarts at 0.
4. Wrap-around with AW=5: store `32'h77` at `0x84` → a load from `0x04` returns `32'h77`.
5. Non-memory instruction with `mwreg=1` between two loads → no stall in its cycle; `mwreg_o=1`; the second load stalls for exactly WAIT_CYCLES cycles.
6. With `PIPEMEM_ALIGN_CHECK_EN`: store `32'h5` to `0x12` → `merr` rises on the completion edge and stays high; `mem[4]` is unchanged; `merr` clears only on `clrn=0`.

Source files
------------

// File: rtl/pipemem_stage.sv
// MEM stage: word-addressed data memory with WAIT_CYCLES wait states and stall.
// Optional misalignment flag merr when PIPEMEM_ALIGN_CHECK_EN is defined.
module pipemem_stage #(
   parameter int AW          = 5,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic        mwmem,
   input  logic [31:0] malu,
   input  logic [31:0] mb,
   output logic [31:0] mmo,
   output logic        mwreg_o,
   output logic        mstall
`ifdef PIPEMEM_ALIGN_CHECK_EN
   ,
   output logic        merr
`endif
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   state_t        state;
   logic [3:0]    cnt;
   logic [31:0]   mem [2**AW];
   logic [AW-1:0] idx;
   logic          memop;
   logic          busy;
   logic          done;
   logic          wen;
   logic          unused_bits;

   assign idx         = malu[AW+1:2];
   assign memop       = mm2reg | mwmem;
   assign busy        = memop & (cnt != WC);
   assign done        = memop & ~busy;
   assign unused_bits = ^{malu[31:AW+2], malu[1:0]};

   assign mstall  = clrn & busy;
   assign mwreg_o = clrn & mwreg & ~busy;
   assign mmo     = clrn ? mem[idx] : 32'h0;

`ifdef PIPEMEM_ALIGN_CHECK_EN
   logic misal;
   assign misal = |malu[1:0];
   assign wen   = clrn & mwmem & done & ~misal;
`else
   assign wen   = clrn & mwmem & done;
`endif

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (memop && WAIT_CYCLES > 0) begin
                  state <= S_WAIT;
                  cnt   <= 4'd1;
               end
            end
            S_WAIT: begin
               // a dropped memop abandons the access
               if (!memop || cnt == WC) begin
                  state <= S_IDLE;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
         endcase
      end
   end

`ifdef PIPEMEM_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (!clrn)
         merr <= 1'b0;
      else if (done && misal)
         merr <= 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (wen)
         mem[idx] <= mb;
   end

endmodule

// File: tb/tb_pipemem_stage.sv
// Bench for pipemem_stage: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
// checked against an array model of the data memory.
module tb_pipemem_stage;

   localparam int AW = 5;
   localparam int W  = 2;
   localparam int NW = 2**AW;

   logic        clk = 1'b0;
   logic        clrn;
   logic        mwreg, mm2reg, mwmem;
   logic [31:0] malu, mb, mmo;
   logic        mwreg_o, mstall;
   logic        z_mwreg, z_mm2reg, z_mwmem;
   logic [31:0] z_malu, z_mb, z_mmo;
   logic        z_mwreg_o, z_mstall;
`ifdef PIPEMEM_ALIGN_CHECK_EN
   logic        merr, z_merr;
`endif

   logic [31:0] ref_mem [NW];
   bit          ref_known [NW];
   logic [31:0] z_mem [NW];
   bit          z_known [NW];
   bit          exp_merr;
   int          n_checks;
   int          n_errors;

   always #5 clk = ~clk;

   pipemem_stage #(.AW(AW), .WAIT_CYCLES(W)) dut (
      .clk(clk), .clrn(clrn), .mwreg(mwreg), .mm2reg(mm2reg),
      .mwmem(mwmem), .malu(malu), .mb(mb), .mmo(mmo),
      .mwreg_o(mwreg_o), .mstall(mstall)
`ifdef PIPEMEM_ALIGN_CHECK_EN
      , .merr(merr)
`endif
   );

   pipemem_stage #(.AW(AW), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .clrn(clrn), .mwreg(z_mwreg), .mm2reg(z_mm2reg),
      .mwmem(z_mwmem), .malu(z_malu), .mb(z_mb), .mmo(z_mmo),
      .mwreg_o(z_mwreg_o), .mstall(z_mstall)
`ifdef PIPEMEM_ALIGN_CHECK_EN
      , .merr(z_merr)
`endif
   );

   // One instruction on the W=2 instance; starts at posedge+1.
   task automatic access(input bit ld, input bit st, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input string tag);
      bit   memop;
      bit   mis;
      int   ncyc;
      int   idx;
      bit   es;
      memop = ld | st;
      ncyc  = memop ? W + 1 : 1;
      idx   = int'(addr[AW+1:2]);
      mis   = addr[1:0] != 2'b00;
      mm2reg = ld; mwmem = st; mwreg = wr; malu = addr; mb = data;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         es = memop && (i < W);
         n_checks++;
         if (mstall !== es) begin
            n_errors++;
            $display("FAIL %s mstall cyc%0d: got %b want %b", tag, i, mstall, es);
         end
         n_checks++;
         if (mwreg_o !== (wr && !es)) begin
            n_errors++;
            $display("FAIL %s mwreg_o cyc%0d: got %b want %b", tag, i, mwreg_o, wr && !es);
         end
`ifdef PIPEMEM_ALIGN_CHECK_EN
         n_checks++;
         if (merr !== exp_merr) begin
            n_errors++;
            $display("FAIL %s merr cyc%0d: got %b want %b", tag, i, merr, exp_merr);
         end
`endif
         if (memop && i == W && ref_known[idx]) begin
            n_checks++;
            if (mmo !== ref_mem[idx]) begin
               n_errors++;
               $display("FAIL %s mmo: got %h want %h", tag, mmo, ref_mem[idx]);
            end
         end
         @(posedge clk); #1;
      end
      if (memop) begin
`ifdef PIPEMEM_ALIGN_CHECK_EN
         if (mis) exp_merr = 1'b1;
         else if (st) begin ref_mem[idx] = data; ref_known[idx] = 1'b1; end
`else
         if (st) begin ref_mem[idx] = data; ref_known[idx] = 1'b1; end
`endif
      end
      mm2reg = 0; mwmem = 0; mwreg = 0;
   endtask

   // One instruction on the W=0 instance (always one cycle, never stalls).
   task automatic z_access(input bit ld, input bit st, input bit wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input string tag);
      int idx;
      idx = int'(addr[AW+1:2]);
      z_mm2reg = ld; z_mwmem = st; z_mwreg = wr; z_malu = addr; z_mb = data;
      @(negedge clk);
      n_checks++;
      if (z_mstall !== 1'b0) begin
         n_errors++;
         $display("FAIL %s z_mstall: got %b want 0", tag, z_mstall);
      end
      n_checks++;
      if (z_mwreg_o !== wr) begin
         n_errors++;
         $display("FAIL %s z_mwreg_o: got %b want %b", tag, z_mwreg_o, wr);
      end
      if ((ld || st) && z_known[idx]) begin
         n_checks++;
         if (z_mmo !== z_mem[idx]) begin
            n_errors++;
            $display("FAIL %s z_mmo: got %h want %h", tag, z_mmo, z_mem[idx]);
         end
      end
      @(posedge clk); #1;
      // aligned-only stimulus here, so a store always commits
      if (st) begin z_mem[idx] = data; z_known[idx] = 1'b1; end
      z_mm2reg = 0; z_mwmem = 0; z_mwreg = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks++;
      if (mstall !== 1'b0 || mwreg_o !== 1'b0 || mmo !== 32'h0) begin
         n_errors++;
         $display("FAIL %s outputs: got stall=%b wreg=%b mmo=%h want 0,0,0",
                  tag, mstall, mwreg_o, mmo);
      end
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      mm2reg = 1; mwmem = 1; mwreg = 1; malu = $urandom; mb = $urandom;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_reset_outputs("reset");
      end
      @(posedge clk); #1;
`ifdef PIPEMEM_ALIGN_CHECK_EN
      n_checks++;
      if (merr !== 1'b0) begin
         n_errors++;
         $display("FAIL reset merr: got %b want 0", merr);
      end
`endif
      mm2reg = 0; mwmem = 0; mwreg = 0;
      clrn = 1'b1;
      exp_merr = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < NW; i++) begin
         access(0, 1, 0, 32'(i * 4), $urandom, "fill");
         z_access(0, 1, 0, 32'(i * 4), $urandom, "zfill");
      end
   endtask

   task automatic test_store_load();
      access(0, 1, 0, 32'h10, 32'hDEADBEEF, "st10");
      access(1, 0, 1, 32'h10, 32'h0, "ld10");
      n_checks++;
      if (ref_mem[4] !== 32'hDEADBEEF) begin
         n_errors++;
         $display("FAIL st10 model: got %h want deadbeef", ref_mem[4]);
      end
   endtask

   task automatic test_wrap();
      access(0, 1, 0, 32'h84, 32'h77, "st84");
      access(1, 0, 1, 32'h04, 32'h0, "ld04");
   endtask

   task automatic test_nonmem_between();
      access(1, 0, 1, 32'h20, 32'h0, "ldA");
      access(0, 0, 1, 32'h20, 32'h0, "alu");
      access(1, 0, 1, 32'h24, 32'h0, "ldB");
      access(1, 1, 1, 32'h24, $urandom, "ldst");
      access(1, 0, 1, 32'h24, 32'h0, "ldC");
   endtask

   task automatic test_back_to_back();
      int op;
      logic [31:0] a;
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 3);
         a  = $urandom;
`ifdef PIPEMEM_ALIGN_CHECK_EN
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
`endif
         access(op[0], op[1], 1'($urandom), a, $urandom, "rand");
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] old8;
      old8 = ref_mem[2];
      mwmem = 1; malu = 32'h8; mb = 32'hAAAA5555; mwreg = 1;
      @(negedge clk);
      n_checks++;
      if (mstall !== 1'b1) begin
         n_errors++;
         $display("FAIL rstmid stall: got %b want 1", mstall);
      end
      @(posedge clk); #1;
      clrn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_reset_outputs("rstmid");
         @(posedge clk); #1;
      end
      clrn = 1'b1; mwmem = 0; mwreg = 0;
      exp_merr = 1'b0;
      // reset landing on the completion cycle must also block the store
      mwmem = 1; malu = 32'h8; mb = 32'h12345678;
      repeat (W) begin @(posedge clk); #1; end
      clrn = 1'b0;
      @(negedge clk);
      check_reset_outputs("rstdone");
      @(posedge clk); #1;
      clrn = 1'b1; mwmem = 0;
      access(1, 0, 1, 32'h8, 32'h0, "ld8");
      n_checks++;
      if (ref_mem[2] !== old8) begin
         n_errors++;
         $display("FAIL rstmid model: got %h want %h", ref_mem[2], old8);
      end
   endtask

`ifdef PIPEMEM_ALIGN_CHECK_EN
   task automatic test_align();
      access(0, 1, 0, 32'h12, 32'h5, "mis");
      access(1, 0, 1, 32'h10, 32'h0, "ld10m");
      access(0, 0, 0, 32'h0, 32'h0, "idle");
      n_checks++;
      if (merr !== 1'b1) begin
         n_errors++;
         $display("FAIL align sticky: got %b want 1", merr);
      end
      clrn = 1'b0;
      @(posedge clk); #1;
      clrn = 1'b1;
      exp_merr = 1'b0;
      n_checks++;
      if (merr !== 1'b0) begin
         n_errors++;
         $display("FAIL align clear: got %b want 0", merr);
      end
   endtask
`endif

   task automatic test_wait0();
      z_access(0, 1, 0, 32'h4, 32'h1, "z_st4");
      z_access(1, 0, 1, 32'h4, 32'h0, "z_ld4");
      for (int n = 0; n < 30; n++)
         z_access(1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom & 32'hFFFF_FFFC, $urandom, "z_rand");
   endtask

   initial begin
      n_checks = 0; n_errors = 0; exp_merr = 1'b0;
      for (int i = 0; i < NW; i++) begin ref_known[i] = 0; z_known[i] = 0; end
      mwreg = 0; mm2reg = 0; mwmem = 0; malu = 0; mb = 0;
      z_mwreg = 0; z_mm2reg = 0; z_mwmem = 0; z_malu = 0; z_mb = 0;
      @(posedge clk); #1;
      test_reset();
      test_fill();
      test_store_load();
      test_wrap();
      test_nonmem_between();
      test_back_to_back();
      test_reset_mid();
`ifdef PIPEMEM_ALIGN_CHECK_EN
      test_align();
`endif
      test_wait0();
      test_store_load();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
